// File: rtl/sti_rx.sv
// STI serial receiver: deserialises one 8/16/24/32-bit frame, undoes the
// transmitter's byte-select/fill packing and flags truncation and bad padding.
module sti_rx (
    input  logic        clk,
    input  logic        reset,
    input  logic        so_valid,
    input  logic        so_data,
    input  logic [1:0]  cfg_length,
    input  logic        cfg_msb,
    input  logic        cfg_low,
    input  logic        cfg_fill,
    output logic [15:0] po_data,
    output logic        po_valid,
    output logic        po_pad_err,
    output logic        po_err,
    output logic        busy,
    output logic [7:0]  frame_cnt
);

    typedef enum logic {IDLE, RECV} state_t;

    state_t      state_q, state_d;
    logic [4:0]  idx_q, idx_d;
    logic [1:0]  len_q, len_d;
    logic        msb_q, msb_d, low_q, low_d, fill_q, fill_d;
    logic [31:0] frame_q, frame_d;
    logic [15:0] data_q, data_d;
    logic        pad_q, pad_d, vld_q, vld_d, err_q, err_d;
    logic [7:0]  cnt_q, cnt_d;

    logic [4:0]  last;
    logic [4:0]  pos;
    logic [31:0] fw;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        len_d   = len_q;
        msb_d   = msb_q;
        low_d   = low_q;
        fill_d  = fill_q;
        frame_d = frame_q;
        data_d  = data_q;
        pad_d   = pad_q;
        vld_d   = 1'b0;
        err_d   = 1'b0;
        cnt_d   = cnt_q;
        // Frame length N is (len+1)*8, so the last bit index is {len,3'b111}.
        last    = {len_q, 3'b111};
        pos     = msb_q ? (last - idx_q) : idx_q;
        // Frame as it will look once the bit on this edge is included.
        fw      = frame_q | ({31'b0, so_data} << pos);

        case (state_q)
            IDLE: begin
                if (so_valid) begin
                    len_d   = cfg_length;
                    msb_d   = cfg_msb;
                    low_d   = cfg_low;
                    fill_d  = cfg_fill;
                    frame_d = {31'b0, so_data} << (cfg_msb ? {cfg_length, 3'b111} : 5'd0);
                    idx_d   = 5'd1;
                    state_d = RECV;
                end
            end
            RECV: begin
                if (!so_valid) begin
                    err_d   = 1'b1;
                    idx_d   = 5'd0;
                    state_d = IDLE;
                end else if (idx_q == last) begin
                    case (len_q)
                        2'd0: begin
                            data_d = low_q ? {8'h00, fw[7:0]} : {fw[7:0], 8'h00};
                            pad_d  = 1'b0;
                        end
                        2'd1: begin
                            data_d = fw[15:0];
                            pad_d  = 1'b0;
                        end
                        2'd2: begin
                            data_d = fill_q ? fw[23:8] : fw[15:0];
                            pad_d  = fill_q ? |fw[7:0] : |fw[23:16];
                        end
                        default: begin
                            data_d = fill_q ? fw[31:16] : fw[15:0];
                            pad_d  = fill_q ? |fw[15:0] : |fw[31:16];
                        end
                    endcase
                    frame_d = fw;
                    vld_d   = 1'b1;
                    cnt_d   = cnt_q + 8'd1;
                    idx_d   = 5'd0;
                    state_d = IDLE;
                end else begin
                    frame_d = fw;
                    idx_d   = idx_q + 5'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            idx_q   <= 5'd0;
            len_q   <= 2'd0;
            msb_q   <= 1'b0;
            low_q   <= 1'b0;
            fill_q  <= 1'b0;
            frame_q <= 32'd0;
            data_q  <= 16'd0;
            pad_q   <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
            cnt_q   <= 8'd0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            len_q   <= len_d;
            msb_q   <= msb_d;
            low_q   <= low_d;
            fill_q  <= fill_d;
            frame_q <= frame_d;
            data_q  <= data_d;
            pad_q   <= pad_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    assign po_data    = data_q;
    assign po_valid   = vld_q;
    assign po_pad_err = pad_q;
    assign po_err     = err_q;
    assign busy       = (state_q == RECV);
    assign frame_cnt  = cnt_q;

endmodule

// File: tb/tb_sti_rx.sv
// Scoreboard bench for sti_rx: expected words queued as frames are driven,
// popped by a monitor whenever po_valid is seen.
module tb_sti_rx;

    logic        clk = 1'b0;
    logic        reset;
    logic        so_valid, so_data;
    logic [1:0]  cfg_length;
    logic        cfg_msb, cfg_low, cfg_fill;
    logic [15:0] po_data;
    logic        po_valid, po_pad_err, po_err, busy;
    logic [7:0]  frame_cnt;

    int checks = 0;
    int errors = 0;
    int vld_seen = 0;
    int err_seen = 0;
    logic [7:0] exp_cnt = 8'd0;
    logic [16:0] exp_q[$];   // {pad_err, data}

    sti_rx dut (
        .clk(clk), .reset(reset), .so_valid(so_valid), .so_data(so_data),
        .cfg_length(cfg_length), .cfg_msb(cfg_msb), .cfg_low(cfg_low), .cfg_fill(cfg_fill),
        .po_data(po_data), .po_valid(po_valid), .po_pad_err(po_pad_err), .po_err(po_err),
        .busy(busy), .frame_cnt(frame_cnt)
    );

    always #5 clk = ~clk;

    // Scoreboard monitor
    always @(negedge clk) begin
        if (reset && po_err) err_seen++;
        if (reset && po_valid) begin
            vld_seen++;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_po_valid: got data=%h pad=%b, expected none", po_data, po_pad_err);
            end else begin
                logic [16:0] e;
                e = exp_q.pop_front();
                if ({po_pad_err, po_data} !== e) begin
                    errors++;
                    $display("FAIL scoreboard: got data=%h pad=%b, expected data=%h pad=%b",
                             po_data, po_pad_err, e[15:0], e[16]);
                end
            end
        end
    end

    // Drive nbits of frame f; cfg is only meaningful on bit 0, so later bits
    // carry random cfg to prove it is latched.
    task automatic send(input logic [1:0] len, input logic msb, input logic low,
                        input logic fill, input logic [31:0] f, input int nbits,
                        input bit chk_busy);
        int n;
        n = (int'(len) + 1) * 8;
        for (int i = 0; i < nbits; i++) begin
            @(negedge clk);
            if (chk_busy && i > 0) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_mid_frame bit %0d: got %b, expected 1", i, busy);
                end
            end
            if (i == 0) begin
                cfg_length = len; cfg_msb = msb; cfg_low = low; cfg_fill = fill;
            end else begin
                cfg_length = 2'($urandom); cfg_msb = 1'($urandom);
                cfg_low = 1'($urandom); cfg_fill = 1'($urandom);
            end
            so_valid = 1'b1;
            so_data  = msb ? f[n-1-i] : f[i];
        end
    endtask

    task automatic idle_after;
        @(negedge clk);
        so_valid = 1'b0;
        so_data  = 1'b0;
    endtask

    task automatic frame(input logic [1:0] len, input logic msb, input logic low,
                         input logic fill, input logic [31:0] f, input logic [15:0] ed,
                         input logic ep);
        exp_q.push_back({ep, ed});
        exp_cnt++;
        send(len, msb, low, fill, f, (int'(len) + 1) * 8, 1'b0);
        idle_after();
        @(negedge clk);
    endtask

    task automatic test_reset;
        reset = 1'b0; so_valid = 1'b0; so_data = 1'b0;
        cfg_length = 2'd0; cfg_msb = 1'b0; cfg_low = 1'b0; cfg_fill = 1'b0;
        #12;
        checks++;
        if ({po_data, po_valid, po_pad_err, po_err, busy, frame_cnt} !== 28'd0) begin
            errors++;
            $display("FAIL reset_state: got data=%h v=%b pad=%b err=%b busy=%b cnt=%0d, expected all 0",
                     po_data, po_valid, po_pad_err, po_err, busy, frame_cnt);
        end
        @(negedge clk); reset = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_16bit_msb;
        exp_q.push_back({1'b0, 16'hA5C3});
        exp_cnt++;
        send(2'd1, 1'b1, 1'b0, 1'b0, 32'h0000A5C3, 16, 1'b1);
        idle_after();
        checks++;
        if (po_valid !== 1'b1 || frame_cnt !== 8'd1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL latency16: got v=%b cnt=%0d busy=%b, expected v=1 cnt=1 busy=0",
                     po_valid, frame_cnt, busy);
        end
        @(negedge clk);
        checks++;
        if (po_valid !== 1'b0 || po_data !== 16'hA5C3) begin
            errors++;
            $display("FAIL valid_single_cycle: got v=%b data=%h, expected v=0 data=a5c3", po_valid, po_data);
        end
    endtask

    task automatic test_8bit;
        frame(2'd0, 1'b0, 1'b1, 1'b0, 32'h3C, 16'h003C, 1'b0);
        frame(2'd0, 1'b0, 1'b0, 1'b0, 32'h3C, 16'h3C00, 1'b0);
    endtask

    task automatic test_fill_pad;
        frame(2'd3, 1'b1, 1'b0, 1'b0, 32'h00001234, 16'h1234, 1'b0);
        frame(2'd3, 1'b1, 1'b0, 1'b0, 32'h00011234, 16'h1234, 1'b1);
        frame(2'd2, 1'b1, 1'b0, 1'b1, 32'h00BEEF00, 16'hBEEF, 1'b0);
        frame(2'd3, 1'b0, 1'b0, 1'b1, 32'hCAFE0001, 16'hCAFE, 1'b1);
        frame(2'd2, 1'b0, 1'b0, 1'b0, 32'h0001ABCD, 16'hABCD, 1'b1);
        frame(2'd2, 1'b1, 1'b0, 1'b1, 32'h00123401, 16'h1234, 1'b1);
    endtask

    task automatic test_truncation;
        int v0, e0;
        v0 = vld_seen; e0 = err_seen;
        send(2'd1, 1'b1, 1'b0, 1'b0, 32'h0000FFFF, 10, 1'b0);
        idle_after();
        @(negedge clk);
        checks++;
        if (po_err !== 1'b1 || po_valid !== 1'b0 || frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL truncation: got err=%b v=%b cnt=%0d, expected err=1 v=0 cnt=%0d",
                     po_err, po_valid, frame_cnt, exp_cnt);
        end
        @(negedge clk);
        checks++;
        if (po_err !== 1'b0 || err_seen != e0 + 1 || vld_seen != v0) begin
            errors++;
            $display("FAIL err_single_pulse: got err=%b pulses=%0d valids=%0d, expected err=0 pulses=1 valids=0",
                     po_err, err_seen - e0, vld_seen - v0);
        end
        frame(2'd1, 1'b1, 1'b0, 1'b0, 32'h000000FF, 16'h00FF, 1'b0);
    endtask

    task automatic test_back_to_back;
        int v0;
        v0 = vld_seen;
        exp_q.push_back({1'b0, 16'hAA00});
        exp_q.push_back({1'b0, 16'h1357});
        exp_cnt += 8'd2;
        send(2'd0, 1'b1, 1'b0, 1'b0, 32'h000000AA, 8, 1'b0);
        send(2'd1, 1'b1, 1'b0, 1'b0, 32'h00001357, 16, 1'b0);
        idle_after();
        @(negedge clk);
        checks++;
        if (vld_seen != v0 + 2 || frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL back_to_back: got pulses=%0d cnt=%0d, expected pulses=2 cnt=%0d",
                     vld_seen - v0, frame_cnt, exp_cnt);
        end
    endtask

    task automatic test_cnt_wrap;
        int n;
        n = 256 - int'(exp_cnt);
        for (int k = 0; k < n; k++) begin
            exp_q.push_back({1'b0, 8'h00, 8'(k)});
            send(2'd0, 1'b0, 1'b1, 1'b0, 32'(k & 8'hFF), 8, 1'b0);
        end
        exp_cnt = 8'd0;
        idle_after();
        @(negedge clk);
        checks++;
        if (frame_cnt !== 8'd0) begin
            errors++;
            $display("FAIL cnt_wrap: got cnt=%0d, expected 0", frame_cnt);
        end
    endtask

    task automatic test_async_reset;
        send(2'd2, 1'b1, 1'b0, 1'b0, 32'h00ABCD, 5, 1'b0);
        @(posedge clk);
        #2 reset = 1'b0;
        #1;
        checks++;
        if ({po_data, po_valid, po_pad_err, po_err, busy, frame_cnt} !== 28'd0) begin
            errors++;
            $display("FAIL async_reset: got data=%h v=%b pad=%b err=%b busy=%b cnt=%0d, expected all 0",
                     po_data, po_valid, po_pad_err, po_err, busy, frame_cnt);
        end
        exp_cnt = 8'd0;
        @(negedge clk);
        so_valid = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        frame(2'd2, 1'b1, 1'b0, 1'b0, 32'h0000ABCD, 16'hABCD, 1'b0);
        checks++;
        if (frame_cnt !== exp_cnt) begin
            errors++;
            $display("FAIL cnt_after_reset: got %0d, expected %0d", frame_cnt, exp_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_16bit_msb();
        test_8bit();
        test_fill_pad();
        test_truncation();
        test_back_to_back();
        test_cnt_wrap();
        test_async_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d words pending, expected 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, expected completion");
        $fatal(1);
    end

endmodule
